// File: rtl/seg_scan_capture_if.sv
// seg_scan_capture_if: seven-segment scan bus plus decoded score readback
// Signals:
//   seg_in[7:0]  segment bus, bit 7 = decimal point, active-low
//   sel_in[3:0]  one-hot digit select, active-low
//   score[15:0]  last published BCD score, [3:0] = units
//   score_valid  score holds a published, non-stale frame
//   frame_pulse  one-cycle strobe on score update
//   bad_glyph    one-cycle strobe on an illegal glyph
//   stale        watchdog expired, cleared by the next publish
// Modports: master drives the display bus, slave is the capture block.
interface seg_scan_capture_if;
  logic [7:0]  seg_in;
  logic [3:0]  sel_in;
  logic [15:0] score;
  logic        score_valid;
  logic        frame_pulse;
  logic        bad_glyph;
  logic        stale;
  modport master (output seg_in, sel_in, input score, score_valid, frame_pulse, bad_glyph, stale);
  modport slave  (input seg_in, sel_in, output score, score_valid, frame_pulse, bad_glyph, stale);
endinterface

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: decodes a multiplexed 4-digit seven-segment scan back into a BCD score
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-low
//   bus  seg_scan_capture_if.slave (segment/select inputs, score and status outputs)
// Parameters:
//   STABLE_CYCLES   identical samples needed to accept a digit (>= 2)
//   TIMEOUT_CYCLES  cycles without an accepted digit before stale is raised
//   WD_W            watchdog counter width, 2**WD_W > TIMEOUT_CYCLES
// Option macro SEG_CAPTURE_DP_CHECK_EN: when defined, a glyph with its
// decimal point lit (seg[7] = 0) is illegal; otherwise seg[7] is ignored.
module seg_scan_capture #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int WD_W           = 20
) (
  input logic               clk,
  input logic               rst,
  seg_scan_capture_if.slave bus
);
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  typedef enum logic [1:0] {WAIT_SYNC, EXP1, EXP2, EXP3} state_e;
  state_e            state_q, state_d;
  logic [7:0]        seg_r_q, seg_r_d;
  logic [3:0]        sel_r_q, sel_r_d;
  logic [RUN_W-1:0]  run_cnt_q, run_cnt_d;
  logic              fired_q, fired_d;
  logic [WD_W-1:0]   wd_cnt_q, wd_cnt_d;
  logic [11:0]       shadow_q, shadow_d;
  logic [15:0]       score_q, score_d;
  logic              score_valid_q, score_valid_d;
  logic              frame_pulse_q, frame_pulse_d;
  logic              bad_glyph_q, bad_glyph_d;
  logic              stale_q, stale_d;
  logic              map_ok, glyph_ok, sel_ok, accept, expire, load, publish;
  logic [3:0]        nib;
  logic [1:0]        k;
  // Stability filter: run_cnt tracks how long the value now in seg_r/sel_r
  // has been unchanged; fired_q remembers that saturation was already seen
  // so the accept is a single-cycle event.
  always_comb begin
    seg_r_d   = bus.seg_in;
    sel_r_d   = bus.sel_in;
    run_cnt_d = ({bus.seg_in, bus.sel_in} != {seg_r_q, sel_r_q}) ? RUN_W'(1) :
                (run_cnt_q == RUN_MAX) ? RUN_MAX : run_cnt_q + RUN_W'(1);
    fired_d   = run_cnt_q == RUN_MAX;
  end
  always_comb begin
    map_ok = 1'b1;
    nib    = 4'd0;
    case (seg_r_q[6:0])
      7'h40:   nib = 4'd0;
      7'h79:   nib = 4'd1;
      7'h24:   nib = 4'd2;
      7'h30:   nib = 4'd3;
      7'h19:   nib = 4'd4;
      7'h12:   nib = 4'd5;
      7'h02:   nib = 4'd6;
      7'h78:   nib = 4'd7;
      7'h00:   nib = 4'd8;
      7'h10:   nib = 4'd9;
      default: map_ok = 1'b0;
    endcase
`ifdef SEG_CAPTURE_DP_CHECK_EN
    glyph_ok = map_ok & seg_r_q[7];
`else
    glyph_ok = map_ok;
`endif
  end
  always_comb begin
    sel_ok = sel_r_q inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
    k      = (sel_r_q == 4'b0111) ? 2'd0 :
             (sel_r_q == 4'b1011) ? 2'd1 :
             (sel_r_q == 4'b1101) ? 2'd2 : 2'd3;
  end
  assign accept = (run_cnt_q == RUN_MAX) & ~fired_q & sel_ok;
  // Expiry fires once, on the edge the watchdog reaches its limit; an
  // accept in the same cycle takes priority and clears the counter.
  assign expire = ~accept & (wd_cnt_q == WD_MAX - WD_W'(1));
  always_comb
    wd_cnt_d = accept ? '0 : (wd_cnt_q == WD_MAX) ? WD_MAX : wd_cnt_q + WD_W'(1);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state_q <= WAIT_SYNC;
    else      state_q <= state_d;
  always_comb begin
    state_d = state_q;
    if (accept)
      state_d = !glyph_ok                     ? WAIT_SYNC :
                (k == 2'd0)                   ? EXP1 :
                (state_q == EXP1 && k == 2'd1) ? EXP2 :
                (state_q == EXP2 && k == 2'd2) ? EXP3 : WAIT_SYNC;
    else if (expire)
      state_d = WAIT_SYNC;
  end
  always_comb begin
    load          = accept & glyph_ok & ((k == 2'd0) | (state_q == EXP1 && k == 2'd1) |
                                         (state_q == EXP2 && k == 2'd2));
    publish       = accept & glyph_ok & (state_q == EXP3) & (k == 2'd3);
    shadow_d      = (accept & ~glyph_ok) ? 12'h000 : shadow_q;
    if (load) shadow_d[{k, 2'b00} +: 4] = nib;
    score_d       = publish ? {nib, shadow_q} : score_q;
    score_valid_d = publish | (score_valid_q & ~expire);
    stale_d       = ~publish & (stale_q | expire);
    frame_pulse_d = publish;
    bad_glyph_d   = accept & ~glyph_ok;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      seg_r_q       <= 8'hFF;
      sel_r_q       <= 4'hF;
      run_cnt_q     <= '0;
      fired_q       <= 1'b0;
      wd_cnt_q      <= '0;
      shadow_q      <= '0;
      score_q       <= '0;
      score_valid_q <= 1'b0;
      frame_pulse_q <= 1'b0;
      bad_glyph_q   <= 1'b0;
      stale_q       <= 1'b0;
    end else begin
      seg_r_q       <= seg_r_d;
      sel_r_q       <= sel_r_d;
      run_cnt_q     <= run_cnt_d;
      fired_q       <= fired_d;
      wd_cnt_q      <= wd_cnt_d;
      shadow_q      <= shadow_d;
      score_q       <= score_d;
      score_valid_q <= score_valid_d;
      frame_pulse_q <= frame_pulse_d;
      bad_glyph_q   <= bad_glyph_d;
      stale_q       <= stale_d;
    end
  assign bus.score       = score_q;
  assign bus.score_valid = score_valid_q;
  assign bus.frame_pulse = frame_pulse_q;
  assign bus.bad_glyph   = bad_glyph_q;
  assign bus.stale       = stale_q;
endmodule

// File: tb/tb_seg_scan_capture.sv
// tb_seg_scan_capture: directed and random scan holds against a frame-level reference model
module tb_seg_scan_capture;
  localparam int S = 4;
  localparam int T = 200;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  seg_scan_capture_if bus ();
  seg_scan_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T), .WD_W(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  int n_chk = 0;
  int n_pass = 0;
  logic [7:0]  glyph [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  int          m_state;
  logic [3:0]  m_sh [3];
  logic [15:0] m_score;
  bit          m_valid, m_stale;
  int          m_idle;
  logic [11:0] prev;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  function automatic int dec(input logic [7:0] s);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] g;
      g = glyph[i];
      if (s[6:0] == g[6:0]) begin
`ifdef SEG_CAPTURE_DP_CHECK_EN
        return s[7] ? i : -1;
`else
        return i;
`endif
      end
    end
    return -1;
  endfunction
  function automatic logic [3:0] sel_of(input int k);
    logic [3:0] one;
    one = 4'h8 >> k;
    return ~one;
  endfunction
  function automatic int digit(input logic [3:0] sel);
    for (int k = 0; k < 4; k++) if (sel == sel_of(k)) return k;
    return -1;
  endfunction
  task automatic model_reset();
    m_state = 0;
    m_score = 16'h0000;
    m_valid = 0;
    m_stale = 0;
    m_idle  = 0;
    prev    = 12'hFFF;
  endtask
  task automatic idle_for(input int span);
    if (m_idle < T && m_idle + span >= T) begin
      m_stale = 1;
      m_valid = 0;
      m_state = 0;
    end
    m_idle += span;
  endtask
  // A hold of d cycles is accepted when d > S; its accept lands on the
  // (S+1)-th edge of the hold, with S idle edges before it.
  task automatic model_hold(input logic [7:0] s, input logic [3:0] l, input int d,
                            output int ep, output int eb);
    int k, g;
    ep = 0;
    eb = 0;
    k = digit(l);
    if (k >= 0 && d > S) begin
      idle_for(S);
      g = dec(s);
      if (g < 0) begin
        eb = 1;
        m_state = 0;
      end else if (k == 0) begin
        m_sh[0] = g[3:0];
        m_state = 1;
      end else if (k < 3 && m_state == k) begin
        m_sh[k] = g[3:0];
        m_state = k + 1;
      end else if (k == 3 && m_state == 3) begin
        m_score = {g[3:0], m_sh[2], m_sh[1], m_sh[0]};
        m_valid = 1;
        m_stale = 0;
        ep = 1;
        m_state = 0;
      end else m_state = 0;
      m_idle = 0;
      idle_for(d - S - 1);
    end else idle_for(d);
  endtask
  task automatic hold(input logic [7:0] s, input logic [3:0] l, input int d);
    int ep, eb, fp, bg, both;
    fp = 0;
    bg = 0;
    both = 0;
    bus.seg_in = s;
    bus.sel_in = l;
    prev = {s, l};
    model_hold(s, l, d, ep, eb);
    repeat (d) begin
      @(posedge clk);
      #1;
      fp += int'(bus.frame_pulse);
      bg += int'(bus.bad_glyph);
      both += int'(bus.frame_pulse & bus.bad_glyph);
    end
    check("frame_pulse_count", fp, ep);
    check("bad_glyph_count", bg, eb);
    check("strobe_overlap", both, 0);
    check("score", bus.score, m_score);
    check("score_valid", bus.score_valid, m_valid);
    check("stale", bus.stale, m_stale);
  endtask
  task automatic frame(input logic [15:0] v, input int d);
    for (int i = 0; i < 4; i++) begin
      logic [3:0] n;
      n = v[4*i +: 4];
      hold(glyph[n], sel_of(i), d);
    end
  endtask
  task automatic check_reset_outputs(input string tag);
    check({tag, "_score"}, bus.score, 16'h0000);
    check({tag, "_valid"}, bus.score_valid, 0);
    check({tag, "_frame_pulse"}, bus.frame_pulse, 0);
    check({tag, "_bad_glyph"}, bus.bad_glyph, 0);
    check({tag, "_stale"}, bus.stale, 0);
  endtask
  initial begin
    bus.seg_in = 8'hFF;
    bus.sel_in = 4'hF;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    frame(16'h1234, 100);
    check("score_1234", bus.score, 16'h1234);
    hold(8'h99, 4'b0111, 10);
    hold(8'hB0, 4'b1011, 2);
    hold(8'hC0, 4'b1011, S - 1);
    hold(8'hB0, 4'b1011, 10);
    hold(8'hA4, 4'b1101, 10);
    hold(8'hF9, 4'b1110, 10);
    check("glitch_score", bus.score, 16'h1234);
    hold(8'hC0, 4'b0111, 10);
    hold(8'hFF, 4'b1011, 10);
    check("bad_keeps_score", bus.score, 16'h1234);
    frame(16'h9000, 10);
    check("score_9000", bus.score, 16'h9000);
    hold(8'hF9, 4'b0111, 10);
    hold(8'hB0, 4'b1101, 10);
    frame(16'h4321, 10);
    check("score_4321", bus.score, 16'h4321);
    hold(8'hFF, 4'b0000, T + 5);
    check("wd_stale", bus.stale, 1);
    check("wd_score_kept", bus.score, 16'h4321);
    frame(16'h5678, 10);
    check("wd_recover_valid", bus.score_valid, 1);
    hold(8'h99, 4'b0111, 10);
    hold(8'hB0, 4'b1011, 10);
    bus.seg_in = 8'hFF;
    bus.sel_in = 4'hF;
    #2 rst = 1'b0;
    #1 check_reset_outputs("midframe_reset");
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    hold(8'h40, 4'b0111, 10);
    for (int n = 0; n < 400; n++) begin
      logic [7:0] s;
      logic [3:0] l;
      int d, r;
      do begin
        r = $urandom_range(0, 9);
        if (r < 7) l = sel_of(($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 3)) : m_state);
        else if (r == 7) l = 4'b0000;
        else if (r == 8) l = 4'b1111;
        else l = 4'($urandom);
        if ($urandom_range(0, 9) == 0) s = 8'($urandom);
        else begin
          s = glyph[$urandom_range(0, 9)];
          s[7] = ($urandom_range(0, 7) != 0);
        end
      end while ({s, l} == prev);
      d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, S - 1)) : int'($urandom_range(S + 1, S + 12));
      hold(s, l, d);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
